// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: steps the AES datapath through ARK0 plus NR rounds, with a watchdog on every step.
module aes_round_sequencer #(
  parameter int NR = 10,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       decrypt,
  input  logic       sub_done,
  input  logic       shift_done,
  input  logic       mix_done,
  input  logic       ark_done,
  output logic       sub_en,
  output logic       shift_en,
  output logic       mix_en,
  output logic       ark_en,
  output logic       ld_state,
  output logic [1:0] src_sel,
  output logic [3:0] key_idx,
  output logic [3:0] round_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, ARK0, SUB, SHIFT, MIX, ARK} state_t;
  localparam logic [3:0] NR4 = 4'(NR);
  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);
  state_t state, nxt;
  logic wt, dec, cur_done, fin, last, new_round;
  logic [7:0] cnt;
  always_comb begin
    cur_done = state == SUB ? sub_done : state == SHIFT ? shift_done :
               state == MIX ? mix_done : (state == ARK0 || state == ARK) ? ark_done : 1'b0;
    fin = wt && cur_done;
    last = round_idx == NR4;
    new_round = state == ARK0 || (dec ? state == MIX : (state == ARK && !last));
    ld_state = fin;
    src_sel = !fin ? 2'd0 : state == SUB ? 2'd0 : state == SHIFT ? 2'd1 : state == MIX ? 2'd2 : 2'd3;
    nxt = IDLE;
    case (state)
      ARK0:    nxt = dec ? SHIFT : SUB;
      SUB:     nxt = dec ? ARK : SHIFT;
      SHIFT:   nxt = dec ? SUB : (last ? ARK : MIX);
      MIX:     nxt = dec ? SHIFT : ARK;
      ARK:     nxt = last ? IDLE : (dec ? MIX : SUB);
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wt <= 1'b0;
      dec <= 1'b0;
      cnt <= '0;
      {sub_en, shift_en, mix_en, ark_en} <= '0;
      key_idx <= '0;
      round_idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      {sub_en, shift_en, mix_en, ark_en} <= '0;
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= ARK0;
          wt <= 1'b0;
          dec <= decrypt;
          ark_en <= 1'b1;
          busy <= 1'b1;
          err <= 1'b0;
          key_idx <= decrypt ? NR4 : 4'd0;
          round_idx <= '0;
          cnt <= '0;
        end
      end else if (!wt) begin
        wt <= 1'b1;
        cnt <= '0;
      end else if (fin) begin
        state <= nxt;
        wt <= 1'b0;
        sub_en <= nxt == SUB;
        shift_en <= nxt == SHIFT;
        mix_en <= nxt == MIX;
        ark_en <= nxt == ARK;
        if (nxt == IDLE) begin
          busy <= 1'b0;
          done <= 1'b1;
          key_idx <= '0;
          round_idx <= '0;
        end else if (new_round) begin
          round_idx <= round_idx + 4'd1;
          key_idx <= dec ? NR4 - round_idx - 4'd1 : round_idx + 4'd1;
        end
      end else if (cnt == TMAX) begin
        // stalled step: abandon the operation without a done pulse
        state <= IDLE;
        wt <= 1'b0;
        busy <= 1'b0;
        err <= 1'b1;
        key_idx <= '0;
        round_idx <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: vector table, random-latency runs against a step-list model, and hand corner cases.
module tb_aes_round_sequencer;
  localparam int NR = 10;
  localparam int TO = 15;
  logic clk = 0, rst = 1, start = 0, decrypt = 0;
  logic sub_done = 0, shift_done = 0, mix_done = 0, ark_done = 0;
  logic sub_en, shift_en, mix_en, ark_en, ld_state, busy, done, err;
  logic [1:0] src_sel;
  logic [3:0] key_idx, round_idx;
  always #5 clk = ~clk;
  aes_round_sequencer #(.NR(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt),
    .sub_done(sub_done), .shift_done(shift_done), .mix_done(mix_done), .ark_done(ark_done),
    .sub_en(sub_en), .shift_en(shift_en), .mix_en(mix_en), .ark_en(ark_en),
    .ld_state(ld_state), .src_sel(src_sel), .key_idx(key_idx), .round_idx(round_idx),
    .busy(busy), .done(done), .err(err)
  );
  typedef struct {int kind; int key; int rnd;} step_t;
  typedef struct {bit d; int lat; bit spur; int exp_done; int e_sub; int e_shift; int e_mix; int e_ark;} vec_t;
  step_t exp_q[$];
  vec_t vecs[4];
  int total = 0, bad = 0;
  int cyc, cur, due, done_cyc, sum, idx;
  int n_en[4];
  logic [3:0] e, dv;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [3:0] ens();
    return {ark_en, mix_en, shift_en, sub_en};
  endfunction
  task automatic put_done(input logic [3:0] v);
    {ark_done, mix_done, shift_done, sub_done} = v;
  endtask
  // expected step list straight from the round recipe; kinds: 0 sub, 1 shift, 2 mix, 3 ark
  task automatic build(input bit d);
    exp_q.delete();
    exp_q.push_back('{3, d ? NR : 0, 0});
    for (int r = 1; r <= NR; r++) begin
      int ks = d ? NR - r : r;
      if (!d) begin
        exp_q.push_back('{0, ks, r});
        exp_q.push_back('{1, ks, r});
        if (r < NR) exp_q.push_back('{2, ks, r});
        exp_q.push_back('{3, ks, r});
      end else begin
        exp_q.push_back('{1, ks, r});
        exp_q.push_back('{0, ks, r});
        exp_q.push_back('{3, ks, r});
        if (r < NR) exp_q.push_back('{2, ks, r});
      end
    end
  endtask
  task automatic run_op(input bit d, input int lat, input bit rnd, input bit spur, input bit hold);
    int l, k;
    build(d);
    idx = 0; sum = 1; done_cyc = -1; cur = -1; due = -1;
    for (int j = 0; j < 4; j++) n_en[j] = 0;
    @(negedge clk);
    start = 1; decrypt = d; put_done(0); cyc = 0;
    while (done_cyc < 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = hold;
      decrypt = 1'($urandom_range(0, 1));
      e = ens();
      for (int j = 0; j < 4; j++) if (e[j]) begin
        n_en[j]++;
        if (idx < exp_q.size()) begin
          chk("step_kind", j, exp_q[idx].kind);
          chk("key_idx", int'(key_idx), exp_q[idx].key);
          chk("round_idx", int'(round_idx), exp_q[idx].rnd);
        end
        idx++;
        cur = j;
        l = rnd ? int'($urandom_range(1, 4)) : lat;
        due = cyc + l;
        sum += l + 1;
      end
      if (done) done_cyc = cyc;
      chk("busy", int'(busy), int'(done_cyc < 0));
      dv = 0;
      if (due == cyc) dv[cur] = 1'b1;
      if (spur && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 3);
        if (k != cur) dv[k] = 1'b1;
      end
      put_done(dv);
      #1;
      chk("ld_state", int'(ld_state), int'(due == cyc));
      if (due == cyc) chk("src_sel", int'(src_sel), cur);
    end
    chk("done_cycle", done_cyc, sum);
    chk("step_count", idx, exp_q.size());
    if (!hold) start = 0;
    put_done(0);
  endtask
  task automatic tick1();
    @(negedge clk);
    cyc++;
    start = 0;
    e = ens();
    for (int j = 0; j < 4; j++) if (e[j]) begin cur = j; due = cyc + 1; end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
  initial begin
    vecs[0] = '{0, 1, 0, 81, 10, 10, 9, 11};
    vecs[1] = '{1, 1, 0, 81, 10, 10, 9, 11};
    vecs[2] = '{0, 3, 1, 161, 10, 10, 9, 11};
    vecs[3] = '{1, 2, 1, 121, 10, 10, 9, 11};
    cyc = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({sub_en, shift_en, mix_en, ark_en, ld_state, src_sel, key_idx, round_idx, busy, done, err}), 0);
    rst = 0;
    foreach (vecs[i]) begin
      run_op(vecs[i].d, vecs[i].lat, 0, vecs[i].spur, 0);
      chk("vec_done", done_cyc, vecs[i].exp_done);
      chk("vec_sub", n_en[0], vecs[i].e_sub);
      chk("vec_shift", n_en[1], vecs[i].e_shift);
      chk("vec_mix", n_en[2], vecs[i].e_mix);
      chk("vec_ark", n_en[3], vecs[i].e_ark);
    end
    repeat (6) run_op(1'($urandom_range(0, 1)), 0, 1, 1, 0);
    // stalled ShiftRows in decrypt mode
    @(negedge clk);
    start = 1; decrypt = 1; cyc = 0; cur = -1; due = -1;
    for (int t = 0; t < 22; t++) begin
      tick1();
      if (cyc == 3) chk("to_shift_en", int'(shift_en), 1);
      if (cyc == 18) begin
        chk("to_busy_pre", int'(busy), 1);
        chk("to_err_pre", int'(err), 0);
      end
      if (cyc >= 19) begin
        chk("to_err", int'(err), 1);
        chk("to_busy", int'(busy), 0);
      end
      chk("to_no_done", int'(done), 0);
      dv = 0;
      if (due == cyc && cur != 1) dv[cur] = 1'b1;
      put_done(dv);
    end
    @(negedge clk);
    start = 1; decrypt = 0; put_done(0);
    @(negedge clk);
    start = 0;
    chk("to_err_cleared", int'(err), 0);
    chk("to_restart_ark", int'(ark_en), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    // reset in the middle of round 5
    @(negedge clk);
    start = 1; decrypt = 0; cyc = 0; cur = -1; due = -1;
    for (int t = 0; t < 40; t++) begin
      tick1();
      dv = 0;
      if (due == cyc) dv[cur] = 1'b1;
      put_done(dv);
    end
    chk("mid_round", int'(round_idx), 5);
    rst = 1; put_done(0);
    @(negedge clk);
    chk("mid_reset_outputs", int'({sub_en, shift_en, mix_en, ark_en, ld_state, src_sel, key_idx, round_idx, busy, done, err}), 0);
    rst = 0;
    run_op(0, 1, 0, 0, 0);
    chk("mid_restart_done", done_cyc, 81);
    // start held high: one done, then immediate re-accept
    run_op(0, 1, 0, 0, 1);
    chk("hold_done", done_cyc, 81);
    @(negedge clk);
    cyc++;
    chk("hold_ark_en", int'(ark_en), 1);
    chk("hold_busy", int'(busy), 1);
    chk("hold_single_done", int'(done), 0);
    start = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Control FSM that sequences the AES step modules (SubBytes, ShiftRows, MixColumns, AddRoundKey, and their inverses) through a full AES encryption or decryption. It pulses each step's `en`, waits for that step's `done`, and routes the step result back into the shared state register. It also drives the round-key index and aborts on a stalled step. It sits between the top-level cipher wrapper and the per-step datapath modules.

## Interface
- `NR`, 10, number of rounds. Legal values: 10, 12, 14.
- `TIMEOUT`, 15, maximum cycles to wait for a step `done` after its `en`. Range 1..255.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin an operation. Sampled only in IDLE.
- `decrypt` in 1: mode. 0 = encrypt, 1 = decrypt. Latched at start.
- `sub_done`, `shift_done`, `mix_done`, `ark_done` in 1 each: step completion pulses.
- `sub_en`, `shift_en`, `mix_en`, `ark_en` out 1 each: one-cycle step enables.
- `ld_state` out 1: load the shared state register from the mux this cycle.
- `src_sel` out 2: state mux select. 0 = sub, 1 = shift, 2 = mix, 3 = ark.
- `key_idx` out 4: round-key index presented to AddRoundKey.
- `round_idx` out 4: current round, 0..NR.
- `busy` out 1: an operation is in progress.
- `done` out 1: one-cycle pulse when an operation completes.
- `err` out 1: sticky timeout flag; cleared on the next accepted start.

## Operation
- States: IDLE, ARK0, SUB, SHIFT, MIX, ARK, WAIT.
  - WAIT is a sub-phase flag, not a separate encoded state.
  - Every step state has an issue cycle (the step's `en` = 1) followed by wait cycles.
- Encrypt sequence:
  - ARK0 (`key_idx` 0).
  - For each r = 1..NR: SUB, SHIFT, MIX, ARK (`key_idx` r).
  - MIX is skipped when r = NR.
- Decrypt sequence (inverse modules wired on the same ports):
  - ARK0 (`key_idx` NR).
  - For each r = 1..NR: SHIFT, SUB, ARK (`key_idx` NR-r), MIX.
  - MIX is skipped when r = NR.
- `round_idx` is 0 during ARK0 and r during round r. `key_idx` is held constant across each round.
- Step completion:
  - A step completes when the `done` matching the current step is high in any cycle after its issue cycle.
  - In that cycle, `ld_state` = 1 and `src_sel` = that step's code (combinational from state and the matching `done`).
  - The next state is entered on the following edge.
- Ignored inputs:
  - A non-matching `done` is ignored.
  - A matching `done` in the issue cycle itself is ignored.
- Watchdog:
  - An 8-bit counter clears on each issue cycle and increments every wait cycle.
  - If it reaches TIMEOUT without a matching `done`, the FSM goes to IDLE and sets `err` = 1.
  - No `done` pulse is produced on timeout.
- `start` while busy is ignored. `decrypt` is ignored except at accept.
- After the final step completes, the FSM returns to IDLE, pulses `done`, and drops `busy`.

## Timing
- Reset values: all enables, `ld_state`, `src_sel`, `key_idx`, `round_idx`, `busy`, `done` and `err` are 0. FSM is in IDLE.
- Reset mid-operation takes effect on the next edge with the same values. No partial `done` is produced.
- Start acceptance:
  - `start` is accepted in cycle 0 (IDLE).
  - Cycle 1: ARK0 issue, `ark_en` = 1, `busy` = 1.
- Step cost: with responders that pulse `done` one cycle after `en`, each step takes 2 cycles. The total is 4·NR steps.
- Completion: the last `ld_state` occurs in cycle 8·NR. In cycle 8·NR+1, `done` = 1 and `busy` = 0. For NR = 10 that is cycle 81.
- A new `start` is accepted in the same cycle `done` is high.
- A responder latency of L cycles gives (L+1) cycles per step.
- Timeout: with `en` in cycle N and no matching `done`, the abort edge is N+TIMEOUT. From cycle N+TIMEOUT+1, `err` = 1 and `busy` = 0.

## Test plan
- Encrypt, NR = 10, 1-cycle responders, start at cycle 0:
  - `done` is high only in cycle 81.
  - Exactly 10 `sub_en`, 10 `shift_en`, 9 `mix_en` and 11 `ark_en` pulses.
  - `ark_en` cycles carry `key_idx` 0,1,…,10.
- Decrypt, NR = 10:
  - Per-round enable order is shift, sub, ark, mix.
  - `ark_en` cycles carry `key_idx` 10,9,…,0.
  - No `mix_en` in round 10.
  - `done` in cycle 81.
- Encrypt with 3-cycle responders: each step takes 4 cycles and `done` lands in cycle 161. Injected spurious `mix_done` during SUB waits causes no state change.
- Timeout, TIMEOUT = 15, `shift_done` tied low:
  - `shift_en` fires in cycle 3; abort at edge 18.
  - `err` = 1 and `busy` = 0 from cycle 19; `done` never pulses.
  - The next `start` clears `err`.
- Reset during round 5 (`rst` 1 cycle):
  - All outputs are 0 the following cycle.
  - A fresh `start` then completes with `done` 81 cycles after it.
- `start` held high for the whole run: exactly one `done`. A second operation is accepted in the `done` cycle and begins with `ark_en` in the following cycle.
